dm_responder: RTL and testbench

//  Multi-cycle data-memory responder: the memory end of the CPU load/store interface.

---
 rtl/dm_pkg.sv | 38 +++
 rtl/dm_lane_align.sv | 47 ++++
 rtl/dm_responder.sv | 144 ++++++++++++++
 tb/tb_dm_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: DMOp codes, FSM encoding and
// byte-lane helpers used by both the responder and its lane aligner.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // Misaligned word/half access or an undefined op code.
  function automatic logic dm_bad_access(input logic [2:0] op, input logic [1:0] addr_lo);
    logic bad;
    case (op)
      DM_WORD:            bad = (addr_lo != 2'b00);
      DM_HALF, DM_HALF_U: bad = addr_lo[0];
      DM_BYTE, DM_BYTE_U: bad = 1'b0;
      default:            bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] dm_lane_mask(input logic [2:0] op, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (op)
      DM_WORD:            mask = 4'b1111;
      DM_HALF, DM_HALF_U: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      DM_BYTE, DM_BYTE_U: mask = 4'b0001 << addr_lo;
      default:            mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering: store lane enables and replicated write data, and
// load extraction with sign/zero extension, all keyed on (op, addr[1:0]).
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [31:0] shifted;
  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    err_o   = dm_bad_access(op_i, addr_lo_i);
    be_o    = err_o ? 4'b0000 : dm_lane_mask(op_i, addr_lo_i);
    shifted = rword_i >> {addr_lo_i, 3'b000};
    half    = shifted[15:0];
    byte_v  = shifted[7:0];
    wword_o = '0;
    rdata_o = '0;
    // Store data is replicated across lanes; the enables pick the live ones.
    case (op_i)
      DM_WORD:            wword_o = wdata_i;
      DM_HALF, DM_HALF_U: wword_o = {2{wdata_i[15:0]}};
      DM_BYTE, DM_BYTE_U: wword_o = {4{wdata_i[7:0]}};
      default:            wword_o = '0;
    endcase
    if (!err_o) begin
      case (op_i)
        DM_WORD:   rdata_o = rword_i;
        DM_HALF:   rdata_o = {{16{half[15]}}, half};
        DM_HALF_U: rdata_o = {16'h0000, half};
        DM_BYTE:   rdata_o = {{24{byte_v[7]}}, byte_v};
        DM_BYTE_U: rdata_o = {24'h000000, byte_v};
        default:   rdata_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: valid/ready request, fixed wait states, one-cycle
// response pulse. Access commits on the edge that enters the response state.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned Words    = 2 ** (ADDR_W - 2);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        op_q;
  logic [31:0]       wdata_q;
  logic              accept, commit, mem_we;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_op;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-3:0] word_idx;
  logic [31:0]       mem [Words];
  logic [31:0]       rword, wword, ext_rdata;
  logic [3:0]        be;
  logic              bad;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid & req_ready;

  // A zero-wait build commits on the accept edge, straight from the request bus.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_op    = req_op;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_op    = op_q;
      acc_wdata = wdata_q;
    end
  end

  assign word_idx = acc_addr[ADDR_W-1:2];
  assign rword    = mem[word_idx];

  dm_lane_align u_align (
    .op_i      (acc_op),
    .addr_lo_i (acc_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wword_o   (wword),
    .rdata_o   (ext_rdata),
    .err_o     (bad)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Held-in-reset requests must never reach the array.
  assign mem_we = commit & rstn & acc_we & ~bad;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      op_q        <= DM_WORD;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        op_q    <= req_op;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        rsp_rdata_q <= acc_we ? '0 : ext_rdata;
        rsp_err_q   <= bad;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Randomized bench for dm_responder: a WAIT_CYCLES=2 instance and a zero-wait instance,
// each checked against a byte-array reference model with per-access latency checks.
module tb_dm_responder;
  import dm_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req_valid_m, req_valid_z;
  logic        req_ready_m, req_ready_z;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [2:0]  req_op;
  logic [31:0] req_wdata;
  logic        rsp_valid_m, rsp_valid_z;
  logic [31:0] rsp_rdata_m, rsp_rdata_z;
  logic        rsp_err_m, rsp_err_z;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_m [2][512];

  dm_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid_m),
    .req_ready (req_ready_m),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_op    (req_op),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid_m),
    .rsp_rdata (rsp_rdata_m),
    .rsp_err   (rsp_err_m)
  );

  dm_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) u_dut_zero (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid_z),
    .req_ready (req_ready_z),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_op    (req_op),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid_z),
    .rsp_rdata (rsp_rdata_z),
    .rsp_err   (rsp_err_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 1) ? req_ready_z : req_ready_m;
  endfunction
  function automatic logic rv(input int sel);
    return (sel == 1) ? rsp_valid_z : rsp_valid_m;
  endfunction
  function automatic logic [31:0] rd(input int sel);
    return (sel == 1) ? rsp_rdata_z : rsp_rdata_m;
  endfunction
  function automatic logic re(input int sel);
    return (sel == 1) ? rsp_err_z : rsp_err_m;
  endfunction
  function automatic int wt(input int sel);
    return (sel == 1) ? 0 : 2;
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 1) req_valid_z = v;
    else req_valid_m = v;
  endtask

  task automatic drive(input logic we, input logic [8:0] addr, input logic [2:0] op,
                       input logic [31:0] wd);
    req_we = we; req_addr = addr; req_op = op; req_wdata = wd;
  endtask

  // Reference: access size from op, alignment by modulo, little-endian byte assembly.
  function automatic void model(input int sel, input logic we, input logic [8:0] addr,
                                input logic [2:0] op, input logic [31:0] wd,
                                output logic [31:0] rdo, output logic er);
    int n;
    bit sx;
    logic [31:0] v;
    n = 0; sx = 0; rdo = '0;
    case (op)
      3'd0: n = 4;
      3'd1: begin n = 2; sx = 1; end
      3'd2: n = 2;
      3'd3: begin n = 1; sx = 1; end
      3'd4: n = 1;
      default: n = 0;
    endcase
    if (n == 0) er = 1'b1;
    else er = ((int'(addr) % n) != 0);
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++) mem_m[sel][int'(addr) + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_m[sel][int'(addr) + i]) << (8 * i));
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rdo = v;
    end
  endfunction

  task automatic run_txn(input int sel, input logic we, input logic [8:0] addr,
                         input logic [2:0] op, input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] er;
    logic        ee;
    int          cyc;
    bit          seen;
    @(negedge clk);
    drive(we, addr, op, wd);
    set_valid(sel, 1'b1);
    cyc = 0;
    while (!rdy(sel) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_ready", 32'(rdy(sel)), 32'd1);
    model(sel, we, addr, op, wd, er, ee);
    @(posedge clk);
    #1 set_valid(sel, 1'b0);
    cyc = 0; seen = 0;
    while (cyc < 20 && !seen) begin
      @(negedge clk);
      cyc++;
      if (rv(sel)) seen = 1;
      else check("ready_low_wait", 32'(rdy(sel)), 32'd0);
    end
    check("rsp_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(wt(sel) + 1));
    check("ready_low_resp", 32'(rdy(sel)), 32'd0);
    check("rdata", rd(sel), er);
    check("err", 32'(re(sel)), 32'(ee));
    got = rd(sel);
  endtask

  // Requester holds valid high across four back-to-back requests.
  task automatic stream(input int sel, input logic [8:0] base);
    logic        we_s [4];
    logic [8:0]  ad_s [4];
    logic [2:0]  op_s [4];
    logic [31:0] wd_s [4];
    logic [31:0] exp_d [$];
    logic        exp_e [$];
    int          exp_c [$];
    logic [31:0] er;
    logic        ee;
    int          acc, nrsp, last, cyc, extra, w;
    we_s = '{1'b1, 1'b0, 1'b1, 1'b0};
    ad_s = '{base, base, base + 9'd1, base + 9'd1};
    op_s = '{DM_WORD, DM_WORD, DM_BYTE, DM_BYTE_U};
    wd_s = '{$urandom(), 32'h0, 32'h80 | ($urandom() & 32'h7F), 32'h0};
    w = wt(sel); acc = 0; nrsp = 0; last = -1; cyc = 0;
    @(negedge clk);
    while (nrsp < 4 && cyc < 60) begin
      if (rv(sel)) begin
        if (exp_c.size() == 0) begin
          check("stream_spurious", 32'(rv(sel)), 32'd0);
        end else begin
          check("stream_latency", 32'(cyc), 32'(exp_c.pop_front()));
          check("stream_rdata", rd(sel), exp_d.pop_front());
          check("stream_err", 32'(re(sel)), 32'(exp_e.pop_front()));
          if (last >= 0) check("stream_spacing", 32'(cyc - last), 32'(w + 2));
          last = cyc;
        end
        nrsp++;
      end
      if (acc < 4) begin
        drive(we_s[acc], ad_s[acc], op_s[acc], wd_s[acc]);
        set_valid(sel, 1'b1);
        if (rdy(sel)) begin
          model(sel, we_s[acc], ad_s[acc], op_s[acc], wd_s[acc], er, ee);
          exp_d.push_back(er);
          exp_e.push_back(ee);
          exp_c.push_back(cyc + w + 1);
          acc++;
        end
      end else begin
        set_valid(sel, 1'b0);
      end
      @(negedge clk);
      cyc++;
    end
    set_valid(sel, 1'b0);
    check("stream_count", 32'(nrsp), 32'd4);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv(sel)) extra++;
    end
    check("stream_extra", 32'(extra), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] old;
    logic [31:0] er;
    logic        ee;
    int          stray;
    rstn = 1'b0; req_valid_m = 1'b0; req_valid_z = 1'b0;
    drive(1'b0, 9'h0, DM_WORD, 32'h0);

    repeat (3) begin
      @(negedge clk);
      check("rst_ready", 32'(req_ready_m), 32'd1);
      check("rst_valid", 32'(rsp_valid_m), 32'd0);
      check("rst_rdata", rsp_rdata_m, 32'h0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready_m), 32'd1);
    check("post_rst_valid", 32'(rsp_valid_m), 32'd0);
    check("post_rst_rdata", rsp_rdata_m, 32'h0);
    check("post_rst_err", 32'(rsp_err_m), 32'd0);
    check("post_rst_ready_z", 32'(req_ready_z), 32'd1);
    check("post_rst_valid_z", 32'(rsp_valid_z), 32'd0);

    // Give every modelled byte a defined value before random loads.
    for (int w = 0; w < 128; w++) run_txn(0, 1'b1, 9'(w * 4), DM_WORD, $urandom(), got);
    for (int w = 0; w < 16; w++) run_txn(1, 1'b1, 9'(w * 4), DM_WORD, $urandom(), got);

    run_txn(0, 1'b1, 9'h10, DM_WORD, 32'hDEAD_BEEF, got);
    run_txn(0, 1'b0, 9'h10, DM_WORD, 32'h0, got);
    check("word_load", got, 32'hDEAD_BEEF);

    run_txn(0, 1'b1, 9'h13, DM_BYTE, 32'h0000_0080, got);
    run_txn(0, 1'b0, 9'h13, DM_BYTE, 32'h0, got);
    check("byte_sext", got, 32'hFFFF_FF80);
    run_txn(0, 1'b0, 9'h13, DM_BYTE_U, 32'h0, got);
    check("byte_zext", got, 32'h0000_0080);
    run_txn(0, 1'b0, 9'h10, DM_WORD, 32'h0, got);
    check("word_after_byte", got, 32'h80AD_BEEF);

    run_txn(0, 1'b0, 9'h11, DM_HALF, 32'h0, got);
    check("half_mis_load", {31'h0, rsp_err_m}, 32'd1);
    run_txn(0, 1'b1, 9'h11, DM_HALF, 32'h1234_5678, got);
    run_txn(0, 1'b0, 9'h10, DM_WORD, 32'h0, got);
    check("half_mis_nowrite", got, 32'h80AD_BEEF);
    run_txn(0, 1'b1, 9'h16, DM_HALF_U, 32'hFFFF_9ABC, got);
    run_txn(0, 1'b0, 9'h16, DM_HALF, 32'h0, got);
    check("half_sext", got, 32'hFFFF_9ABC);

    stream(0, 9'h80);
    stream(1, 9'h20);

    // Reset lands while a store is in its wait states.
    model(0, 1'b0, 9'h40, DM_WORD, 32'h0, old, ee);
    @(negedge clk);
    drive(1'b1, 9'h40, DM_WORD, ~old);
    req_valid_m = 1'b1;
    @(posedge clk);
    #1 req_valid_m = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready_m), 32'd1);
    check("midrst_valid", 32'(rsp_valid_m), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_m) stray++;
    end
    check("midrst_no_rsp", 32'(stray), 32'd0);
    run_txn(0, 1'b0, 9'h40, DM_WORD, 32'h0, got);
    check("midrst_old_data", got, old);

    for (int k = 0; k < 80; k++) begin
      logic [8:0] a;
      a = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(0, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom(), got);
    end
    for (int k = 0; k < 30; k++) begin
      logic [8:0] a;
      a = 9'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(1, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom(), got);
    end
    model(1, 1'b0, 9'h20, DM_WORD, 32'h0, er, ee);
    run_txn(1, 1'b0, 9'h20, DM_WORD, 32'h0, got);
    check("zero_final_word", got, er);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
